frag_writer: RTL and testbench

Fragment back-end for the Celery3D pipeline: consumes the `fragment_t` stream produced by the rasterizer, performs the Glide-compatible depth test against a 16-bit Z-buffer, and emits RGB565 colour and Z writes to the framebuffer memory ports. It sits between the rasterizer output and the framebuffer/Z-buffer memory controller, and is the receiving end of the rasterizer's fragment interface.

---
 rtl/celery_pkg.sv | 74 +++++++
 rtl/frag_colorpack.sv | 21 ++
 rtl/frag_writer.sv | 157 +++++++++++++++
 tb/tb_frag_writer.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/celery_pkg.sv
`default_nettype none
// ============================================================================
// Package  : celery_pkg
// Brief    : Shared Celery3D fixed-point, fragment and depth-test definitions
// Revision : 1.0
// ============================================================================
package celery_pkg;

    typedef logic signed [31:0] fp32_t;   // S15.16
    typedef logic [15:0]        z16_t;

    localparam fp32_t FP_ONE = 32'sh0001_0000;

    typedef enum logic [2:0] {
        GR_CMP_NEVER    = 3'd0,  // never passes
        GR_CMP_LESS     = 3'd1,  // new <  buf
        GR_CMP_EQUAL    = 3'd2,  // new == buf
        GR_CMP_LEQUAL   = 3'd3,  // new <= buf
        GR_CMP_GREATER  = 3'd4,  // new >  buf
        GR_CMP_NOTEQUAL = 3'd5,  // new != buf
        GR_CMP_GEQUAL   = 3'd6,  // new >= buf
        GR_CMP_ALWAYS   = 3'd7   // always passes
    } depth_func_t;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        fp32_t       z;
        fp32_t       r;
        fp32_t       g;
        fp32_t       b;
        logic        valid;
    } fragment_t;

    // Clamp to [0, FP_ONE-1] and keep the top 'bits' fraction bits.
    function automatic logic [15:0] fp_to_unorm(fp32_t v, int bits);
        logic [15:0] c;
        if (v < 0)
            c = 16'h0000;
        else if (v >= FP_ONE)
            c = 16'hFFFF;
        else
            c = v[15:0];
        return c >> (16 - bits);
    endfunction

    function automatic z16_t fp_to_z16(fp32_t z);
        if (z < 0)
            return 16'h0000;
        else if (z >= FP_ONE)
            return 16'hFFFF;
        else
            return z[15:0];
    endfunction

    function automatic logic depth_pass(depth_func_t f, z16_t new_z, z16_t buf_z);
        case (f)
            GR_CMP_NEVER:    return 1'b0;
            GR_CMP_LESS:     return new_z <  buf_z;
            GR_CMP_EQUAL:    return new_z == buf_z;
            GR_CMP_LEQUAL:   return new_z <= buf_z;
            GR_CMP_GREATER:  return new_z >  buf_z;
            GR_CMP_NOTEQUAL: return new_z != buf_z;
            GR_CMP_GEQUAL:   return new_z >= buf_z;
            default:         return 1'b1;
        endcase
    endfunction

    function automatic logic [15:0] pack_rgb565(logic [4:0] r, logic [5:0] g, logic [4:0] b);
        return {r, g, b};
    endfunction

endpackage
`default_nettype wire

// File: rtl/frag_colorpack.sv
`default_nettype none
// ============================================================================
// Module   : frag_colorpack
// Brief    : Clamps S15.16 RGB channels and packs them into RGB565
// Revision : 1.0
// ============================================================================
module frag_colorpack
    import celery_pkg::*;
(
    input  fp32_t       r,
    input  fp32_t       g,
    input  fp32_t       b,
    output logic [15:0] rgb565
);

    assign rgb565 = pack_rgb565(5'(fp_to_unorm(r, 5)),
                                6'(fp_to_unorm(g, 6)),
                                5'(fp_to_unorm(b, 5)));

endmodule
`default_nettype wire

// File: rtl/frag_writer.sv
`default_nettype none
// ============================================================================
// Module   : frag_writer
// Brief    : Depth-tests rasterizer fragments and issues RGB565 / Z16 writes
// Revision : 1.0
// ============================================================================
module frag_writer
    import celery_pkg::*;
#(
    parameter int FB_WIDTH  = 640,
    parameter int FB_HEIGHT = 480,
    parameter int ADDR_BITS = 19
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  fragment_t            frag_in,
    input  logic                 frag_valid,
    output logic                 frag_ready,
    input  logic                 depth_test_en,
    input  depth_func_t          depth_func,
    input  logic                 depth_write_en,
    input  logic                 color_write_en,
    output logic                 z_rd_en,
    output logic [ADDR_BITS-1:0] z_rd_addr,
    input  z16_t                 z_rd_data,
    input  logic                 z_rd_valid,
    output logic                 z_wr_en,
    output logic [ADDR_BITS-1:0] z_wr_addr,
    output z16_t                 z_wr_data,
    output logic                 fb_wr_en,
    output logic [ADDR_BITS-1:0] fb_wr_addr,
    output logic [15:0]          fb_wr_data,
    input  logic                 fb_wr_ready,
    output logic [31:0]          cnt_written,
    output logic [31:0]          cnt_zkilled,
    output logic [31:0]          cnt_clipped
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_Z_READ = 2'd1;
    localparam logic [1:0] S_Z_WAIT = 2'd2;
    localparam logic [1:0] S_WRITE  = 2'd3;

    localparam logic [31:0] c_fb_width  = 32'(FB_WIDTH);
    localparam logic [31:0] c_fb_height = 32'(FB_HEIGHT);

    logic [1:0]           r_state;
    logic [ADDR_BITS-1:0] r_addr;
    z16_t                 r_z16;
    logic [15:0]          r_color;
    depth_func_t          r_func;
    logic                 r_dwe;
    logic                 r_cwe;

    logic [15:0]          w_color;
    logic [ADDR_BITS-1:0] w_addr;
    logic                 w_clip;
    logic                 w_accept;
    logic                 w_fb_done;

    frag_colorpack u_colorpack (
        .r      (frag_in.r),
        .g      (frag_in.g),
        .b      (frag_in.b),
        .rgb565 (w_color)
    );

    assign frag_ready = (r_state == S_IDLE);
    assign w_accept   = frag_valid && frag_ready;
    assign w_addr     = ADDR_BITS'(32'(frag_in.y) * c_fb_width + 32'(frag_in.x));
    assign w_clip     = (32'(frag_in.x) >= c_fb_width) || (32'(frag_in.y) >= c_fb_height);
    // With colour writes masked, the write phase completes without a handshake.
    assign w_fb_done  = !r_cwe || (fb_wr_en && fb_wr_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_z16       <= '0;
            r_color     <= '0;
            r_func      <= GR_CMP_NEVER;
            r_dwe       <= 1'b0;
            r_cwe       <= 1'b0;
            z_rd_en     <= 1'b0;
            z_rd_addr   <= '0;
            z_wr_en     <= 1'b0;
            z_wr_addr   <= '0;
            z_wr_data   <= '0;
            fb_wr_en    <= 1'b0;
            fb_wr_addr  <= '0;
            fb_wr_data  <= '0;
            cnt_written <= '0;
            cnt_zkilled <= '0;
            cnt_clipped <= '0;
        end else begin
            z_rd_en <= 1'b0;
            z_wr_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr  <= w_addr;
                        r_z16   <= fp_to_z16(frag_in.z);
                        r_color <= w_color;
                        r_func  <= depth_func;
                        r_dwe   <= depth_write_en;
                        r_cwe   <= color_write_en;
                        if (frag_in.valid) begin
                            if (w_clip) begin
                                cnt_clipped <= cnt_clipped + 32'd1;
                            end else if (depth_test_en) begin
                                r_state   <= S_Z_READ;
                                z_rd_en   <= 1'b1;
                                z_rd_addr <= w_addr;
                            end else begin
                                r_state    <= S_WRITE;
                                fb_wr_en   <= color_write_en;
                                fb_wr_addr <= w_addr;
                                fb_wr_data <= w_color;
                            end
                        end
                    end
                end
                S_Z_READ: begin
                    r_state <= S_Z_WAIT;
                end
                S_Z_WAIT: begin
                    if (z_rd_valid) begin
                        if (depth_pass(r_func, r_z16, z_rd_data)) begin
                            r_state    <= S_WRITE;
                            fb_wr_en   <= r_cwe;
                            fb_wr_addr <= r_addr;
                            fb_wr_data <= r_color;
                        end else begin
                            r_state     <= S_IDLE;
                            cnt_zkilled <= cnt_zkilled + 32'd1;
                        end
                    end
                end
                S_WRITE: begin
                    if (w_fb_done) begin
                        r_state     <= S_IDLE;
                        fb_wr_en    <= 1'b0;
                        cnt_written <= cnt_written + 32'd1;
                        if (r_dwe) begin
                            z_wr_en   <= 1'b1;
                            z_wr_addr <= r_addr;
                            z_wr_data <= r_z16;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frag_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_frag_writer
// Brief    : Scoreboard bench for frag_writer with a Z-buffer memory model
// Revision : 1.0
// ============================================================================
module tb_frag_writer;
    import celery_pkg::*;

    localparam int W  = 640;
    localparam int H  = 480;
    localparam int AB = 19;

    typedef struct { int addr; int data; } wr_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    fragment_t       frag_in;
    logic            frag_valid;
    logic            frag_ready;
    logic            depth_test_en;
    depth_func_t     depth_func;
    logic            depth_write_en;
    logic            color_write_en;
    logic            z_rd_en;
    logic [AB-1:0]   z_rd_addr;
    logic [15:0]     z_rd_data;
    logic            z_rd_valid;
    logic            z_wr_en;
    logic [AB-1:0]   z_wr_addr;
    logic [15:0]     z_wr_data;
    logic            fb_wr_en;
    logic [AB-1:0]   fb_wr_addr;
    logic [15:0]     fb_wr_data;
    logic            fb_wr_ready;
    logic [31:0]     cnt_written;
    logic [31:0]     cnt_zkilled;
    logic [31:0]     cnt_clipped;

    frag_writer #(.FB_WIDTH(W), .FB_HEIGHT(H), .ADDR_BITS(AB)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .frag_in        (frag_in),
        .frag_valid     (frag_valid),
        .frag_ready     (frag_ready),
        .depth_test_en  (depth_test_en),
        .depth_func     (depth_func),
        .depth_write_en (depth_write_en),
        .color_write_en (color_write_en),
        .z_rd_en        (z_rd_en),
        .z_rd_addr      (z_rd_addr),
        .z_rd_data      (z_rd_data),
        .z_rd_valid     (z_rd_valid),
        .z_wr_en        (z_wr_en),
        .z_wr_addr      (z_wr_addr),
        .z_wr_data      (z_wr_data),
        .fb_wr_en       (fb_wr_en),
        .fb_wr_addr     (fb_wr_addr),
        .fb_wr_data     (fb_wr_data),
        .fb_wr_ready    (fb_wr_ready),
        .cnt_written    (cnt_written),
        .cnt_zkilled    (cnt_zkilled),
        .cnt_clipped    (cnt_clipped)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned e_written = 0, e_zkilled = 0, e_clipped = 0;
    wr_t         exp_fb[$];
    wr_t         exp_z[$];
    int          exp_rd[$];
    logic [15:0] mem_z[int];
    logic [15:0] ref_z[int];
    int          fb_mode = 0;
    int          rd_lat = 1;
    bit          rd_lat_rand = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s", nm);
    endtask

    function automatic int clamp16(input fp32_t v);
        if (int'(v) < 0)      return 0;
        if (int'(v) >= 65536) return 65535;
        return int'(v);
    endfunction

    function automatic bit ref_cmp(input depth_func_t fn, input int n, input int b);
        case (fn)
            GR_CMP_NEVER:    return 0;
            GR_CMP_LESS:     return n < b;
            GR_CMP_EQUAL:    return n == b;
            GR_CMP_LEQUAL:   return n <= b;
            GR_CMP_GREATER:  return n > b;
            GR_CMP_NOTEQUAL: return n != b;
            GR_CMP_GEQUAL:   return n >= b;
            default:         return 1;
        endcase
    endfunction

    // Reference behaviour for one fragment, in arrival order.
    task automatic model(input fragment_t f, input logic dte, input depth_func_t fn,
                         input logic dwe, input logic cwe);
        int a, z16, col, bz;
        bit pass;
        if (!f.valid) return;
        if (int'(f.x) >= W || int'(f.y) >= H) begin
            e_clipped++;
            return;
        end
        a   = int'(f.y) * W + int'(f.x);
        z16 = clamp16(f.z);
        col = (clamp16(f.r) / 2048) * 2048 + (clamp16(f.g) / 1024) * 32 + clamp16(f.b) / 2048;
        pass = 1;
        if (dte) begin
            exp_rd.push_back(a);
            bz   = ref_z.exists(a) ? int'(ref_z[a]) : 0;
            pass = ref_cmp(fn, z16, bz);
        end
        if (!pass) begin
            e_zkilled++;
            return;
        end
        e_written++;
        if (cwe) exp_fb.push_back('{a, col});
        if (dwe) begin
            exp_z.push_back('{a, z16});
            ref_z[a] = 16'(z16);
        end
    endtask

    function automatic fragment_t mk(input int x, input int y, input fp32_t z,
                                     input fp32_t r, input fp32_t g, input fp32_t b, input logic v);
        fragment_t f;
        f.x = 16'(x); f.y = 16'(y); f.z = z;
        f.r = r; f.g = g; f.b = b; f.valid = v;
        return f;
    endfunction

    task automatic send(input fragment_t f, input logic dte, input depth_func_t fn,
                        input logic dwe, input logic cwe);
        int n;
        model(f, dte, fn, dwe, cwe);
        @(negedge clk);
        frag_in = f; depth_test_en = dte; depth_func = fn;
        depth_write_en = dwe; color_write_en = cwe; frag_valid = 1'b1;
        n = 0;
        while (!frag_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!frag_ready) fail_now("accept_timeout");
        @(posedge clk);
        #1 frag_valid = 1'b0;
    endtask

    // Z-buffer memory: answers each read after a configurable latency.
    initial begin : z_mem
        int lat, a;
        z_rd_valid = 1'b0;
        z_rd_data  = 16'h0;
        forever begin
            @(negedge clk);
            if (z_rd_en) begin
                a   = int'(z_rd_addr);
                lat = rd_lat_rand ? int'($urandom_range(1, 4)) : rd_lat;
                repeat (lat) @(negedge clk);
                z_rd_data  = mem_z.exists(a) ? mem_z[a] : 16'h0;
                z_rd_valid = 1'b1;
                @(negedge clk);
                z_rd_valid = 1'b0;
                z_rd_data  = 16'($urandom);
            end
        end
    end

    initial begin : fb_ready_drv
        fb_wr_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (fb_mode)
                0:       fb_wr_ready = 1'b1;
                1:       fb_wr_ready = ($urandom_range(0, 9) < 7);
                default: fb_wr_ready = 1'b0;
            endcase
        end
    end

    initial begin : monitor
        bit          pend;
        logic [AB-1:0] pa;
        logic [15:0] pd;
        wr_t         e;
        int          ra;
        pend = 0; pa = '0; pd = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 0;
            end else begin
                if (pend) begin
                    chk("fb_hold_en", fb_wr_en, 1);
                    chk("fb_hold_addr", fb_wr_addr, pa);
                    chk("fb_hold_data", fb_wr_data, pd);
                end
                pend = fb_wr_en && !fb_wr_ready;
                pa = fb_wr_addr;
                pd = fb_wr_data;
                if (fb_wr_en && fb_wr_ready) begin
                    if (exp_fb.size() == 0) fail_now("fb_unexpected_write");
                    else begin
                        e = exp_fb.pop_front();
                        chk("fb_addr", fb_wr_addr, e.addr);
                        chk("fb_data", fb_wr_data, e.data);
                    end
                end
                if (z_wr_en) begin
                    mem_z[int'(z_wr_addr)] = z_wr_data;
                    if (exp_z.size() == 0) fail_now("z_unexpected_write");
                    else begin
                        e = exp_z.pop_front();
                        chk("z_wr_addr", z_wr_addr, e.addr);
                        chk("z_wr_data", z_wr_data, e.data);
                    end
                end
                if (z_rd_en) begin
                    if (exp_rd.size() == 0) fail_now("z_unexpected_read");
                    else begin
                        ra = exp_rd.pop_front();
                        chk("z_rd_addr", z_rd_addr, ra);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "simulation time limit reached");
    end

    initial begin : main
        fragment_t f;
        int n, x, y, a;
        fp32_t ch[5];
        frag_valid = 1'b0; frag_in = '0; depth_test_en = 1'b0; depth_func = GR_CMP_ALWAYS;
        depth_write_en = 1'b0; color_write_en = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_frag_ready", frag_ready, 1);
        chk("rst_z_rd_en", z_rd_en, 0);
        chk("rst_z_wr_en", z_wr_en, 0);
        chk("rst_fb_wr_en", fb_wr_en, 0);
        chk("rst_fb_wr_addr", fb_wr_addr, 0);
        chk("rst_fb_wr_data", fb_wr_data, 0);
        chk("rst_cnt_written", cnt_written, 0);
        chk("rst_cnt_zkilled", cnt_zkilled, 0);
        chk("rst_cnt_clipped", cnt_clipped, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_frag_ready", frag_ready, 1);

        // Depth test off: write visible the cycle after accept.
        send(mk(10, 2, 0, FP_ONE, FP_ONE, FP_ONE, 1), 0, GR_CMP_ALWAYS, 0, 1);
        @(negedge clk);
        chk("nodepth_fb_en_t1", fb_wr_en, 1);
        chk("nodepth_fb_addr_t1", fb_wr_addr, 1290);
        chk("nodepth_fb_data_t1", fb_wr_data, 16'hFFFF);
        @(negedge clk);
        chk("nodepth_ready_t2", frag_ready, 1);
        chk("nodepth_cnt_written", cnt_written, 1);

        // LESS pass then LESS fail at address 645.
        mem_z[645] = 16'h8000; ref_z[645] = 16'h8000;
        send(mk(5, 1, 32'sh4000, 0, 0, 0, 1), 1, GR_CMP_LESS, 1, 1);
        @(negedge clk);
        chk("less_z_rd_en_t1", z_rd_en, 1);
        chk("less_z_rd_addr_t1", z_rd_addr, 645);
        @(negedge clk);
        chk("less_fb_en_t2", fb_wr_en, 0);
        @(negedge clk);
        chk("less_fb_en_t3", fb_wr_en, 1);
        @(negedge clk);
        chk("less_z_wr_en_t4", z_wr_en, 1);
        chk("less_z_wr_data_t4", z_wr_data, 16'h4000);
        @(negedge clk);
        chk("less_z_wr_en_t5", z_wr_en, 0);
        mem_z[645] = 16'h2000; ref_z[645] = 16'h2000;
        send(mk(5, 1, 32'sh4000, 0, 0, 0, 1), 1, GR_CMP_LESS, 1, 1);
        repeat (6) @(negedge clk);
        chk("kill_cnt_zkilled", cnt_zkilled, 1);
        chk("kill_cnt_written", cnt_written, e_written);

        // Clipping on both axes and a dropped invalid fragment.
        send(mk(640, 0, 0, 0, 0, 0, 1), 1, GR_CMP_ALWAYS, 1, 1);
        @(negedge clk);
        chk("clip_x_ready", frag_ready, 1);
        chk("clip_x_cnt", cnt_clipped, 1);
        send(mk(10, 480, 0, 0, 0, 0, 1), 0, GR_CMP_ALWAYS, 1, 1);
        send(mk(1, 1, 0, FP_ONE, 0, 0, 0), 0, GR_CMP_ALWAYS, 1, 1);
        repeat (3) @(negedge clk);
        chk("clip_y_cnt", cnt_clipped, 2);
        chk("drop_cnt_written", cnt_written, e_written);

        // Colour clamp: negative, over-range and mid-range channels.
        send(mk(0, 0, 0, -32'sh10000, 32'sh20000, 32'sh8000, 1), 0, GR_CMP_ALWAYS, 0, 1);
        @(negedge clk);
        chk("clamp_fb_data", fb_wr_data, 16'h07F0);

        // Framebuffer back-pressure for five cycles.
        repeat (2) @(negedge clk);
        fb_mode = 2;
        @(posedge clk);
        send(mk(7, 0, 32'sh1234, FP_ONE, 0, 0, 1), 0, GR_CMP_ALWAYS, 1, 1);
        repeat (5) begin
            @(negedge clk);
            chk("stall_fb_en", fb_wr_en, 1);
            chk("stall_frag_ready", frag_ready, 0);
            chk("stall_z_wr_en", z_wr_en, 0);
        end
        fb_mode = 0;
        repeat (4) @(negedge clk);
        chk("stall_cnt_written", cnt_written, e_written);

        // Reset while waiting for Z read data abandons the fragment.
        rd_lat = 4;
        send(mk(3, 2, 32'sh100, FP_ONE, FP_ONE, 0, 1), 1, GR_CMP_ALWAYS, 0, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstmid_z_rd_en", z_rd_en, 0);
        chk("rstmid_fb_wr_en", fb_wr_en, 0);
        chk("rstmid_z_wr_en", z_wr_en, 0);
        exp_fb.delete(); exp_z.delete();
        e_written = 0; e_zkilled = 0; e_clipped = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("rstmid_cnt_written", cnt_written, 0);
        chk("rstmid_cnt_zkilled", cnt_zkilled, 0);
        chk("rstmid_cnt_clipped", cnt_clipped, 0);
        chk("rstmid_frag_ready", frag_ready, 1);
        rd_lat = 1;

        // Randomised traffic over a small tile plus the framebuffer edges.
        for (int yy = 0; yy < 3; yy++)
            for (int xx = 0; xx < 4; xx++) begin
                a = yy * W + xx;
                mem_z[a] = 16'($urandom);
                ref_z[a] = mem_z[a];
            end
        rd_lat_rand = 1;
        fb_mode = 1;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0:       x = 639 + int'($urandom_range(0, 1));
                1:       x = 700 + int'($urandom_range(0, 100));
                default: x = int'($urandom_range(0, 3));
            endcase
            case ($urandom_range(0, 9))
                0:       y = 479 + int'($urandom_range(0, 1));
                default: y = int'($urandom_range(0, 2));
            endcase
            a = y * W + x;
            ch[0] = -fp32_t'($urandom_range(1, 100000));
            ch[1] = FP_ONE + fp32_t'($urandom_range(0, 1000));
            ch[2] = FP_ONE - 1;
            ch[3] = fp32_t'($urandom_range(0, 65535));
            ch[4] = fp32_t'($urandom_range(0, 65535));
            case ($urandom_range(0, 3))
                0: f.z = ch[$urandom_range(0, 2)];
                1: f.z = fp32_t'(ref_z.exists(a) ? {16'h0, ref_z[a]} : 32'h0);
                default: f.z = ch[3];
            endcase
            f.x = 16'(x); f.y = 16'(y);
            f.r = ch[$urandom_range(0, 4)];
            f.g = ch[$urandom_range(0, 4)];
            f.b = ch[$urandom_range(0, 4)];
            f.valid = ($urandom_range(0, 9) != 0);
            send(f, 1'($urandom_range(0, 3) != 0), depth_func_t'($urandom_range(0, 7)),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0));
        end
        n = 0;
        while ((exp_fb.size() != 0 || exp_z.size() != 0 || exp_rd.size() != 0 || !frag_ready)
               && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) fail_now("drain_timeout");
        repeat (3) @(negedge clk);
        chk("rand_cnt_written", cnt_written, e_written);
        chk("rand_cnt_zkilled", cnt_zkilled, e_zkilled);
        chk("rand_cnt_clipped", cnt_clipped, e_clipped);
        chk("rand_fb_queue_left", exp_fb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
